dcache_miss_handler: RTL and testbench
======================================

DCACHE_MISS_HANDLER -- requirements
Module: dcache_miss_handler

Interface
REQ-001 SHALL have parameter RESP_TIMEOUT_CYCLES, default 1023: max RD_WAIT cycles before timeout_err sets; 0 disables.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_aL  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port miss_valid  input  1  dcache presents a miss.
REQ-005 SHALL have port miss_ready  output  1  handler accepts a miss.
REQ-006 SHALL have port miss_block_addr  input  main_mem_block_addr_t  block to fill.
REQ-007 SHALL have port miss_victim_dirty  input  1  victim needs writeback.
REQ-008 SHALL have port miss_victim_block_addr  input  main_mem_block_addr_t  victim address.
REQ-009 SHALL have port miss_victim_block_data  input  block_data_t  victim data.
REQ-010 SHALL have port dcache_req_valid  output  1  request to mem_ctrl.
REQ-011 SHALL have port dcache_req_type  output  req_type_t  READ or WRITE.
REQ-012 SHALL have port dcache_req_block_addr  output  main_mem_block_addr_t  request address.
REQ-013 SHALL have port dcache_req_block_data  output  block_data_t  write data.
REQ-014 SHALL have port dcache_req_ready  input  1  mem_ctrl accepts request.
REQ-015 SHALL have port dcache_resp_valid  input  1  read data valid (no back-pressure).
REQ-016 SHALL have port dcache_resp_block_data  input  block_data_t  read data.
REQ-017 SHALL have port fill_valid  output  1  one-cycle pulse, fill ready for dcache.
REQ-018 SHALL have port fill_block_addr  output  main_mem_block_addr_t  filled address.
REQ-019 SHALL have port fill_block_data  output  block_data_t  filled data.
REQ-020 SHALL have ports timeout_err and spurious_resp_err  output  1 each  sticky error flags.

Function
REQ-021 SHALL implement states IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL.
REQ-022 SHALL assert miss_ready only in IDLE; miss accepted on miss_valid && miss_ready, capturing all miss_* inputs into registers.
REQ-023 SHALL transition IDLE->WB_REQ on acceptance if victim dirty, else IDLE->RD_REQ.
REQ-024 SHALL in WB_REQ drive valid=1, type=WRITE, captured victim addr/data; on dcache_req_ready go to RD_REQ next cycle.
REQ-025 SHALL treat writes as complete on handshake; no write response expected.
REQ-026 SHALL in RD_REQ drive valid=1, type=READ, captured miss addr, data=0; on dcache_req_ready go to RD_WAIT.
REQ-027 SHALL hold all dcache_req_* outputs stable while valid=1 and ready=0.
REQ-028 SHALL drive dcache_req_valid=0 in IDLE, RD_WAIT, FILL.
REQ-029 SHALL in RD_WAIT capture dcache_resp_block_data on first dcache_resp_valid and go to FILL.
REQ-030 SHALL in FILL assert fill_valid for exactly one cycle with captured addr/data, then return to IDLE; no new miss accepted in FILL.
REQ-031 SHALL count RD_WAIT cycles (counter cleared on RD_WAIT entry, saturating); at count==RESP_TIMEOUT_CYCLES (nonzero) set timeout_err, remain in RD_WAIT.
REQ-032 SHALL set spurious_resp_err on dcache_resp_valid in any state other than RD_WAIT; response ignored, state unchanged.
REQ-033 SHALL keep error flags set until reset.
REQ-034 SHALL ignore miss_valid outside IDLE; captured registers do not change.
REQ-035 SHALL give min latency: clean miss, ready=1, resp 1 cycle after RD_WAIT entry -> fill_valid 4 cycles after acceptance edge; dirty adds 1 cycle.

Reset
REQ-036 SHALL on rst_aL low immediately enter IDLE, clear captured registers, counter and error flags.
REQ-037 SHALL drive reset outputs: miss_ready=1 after reset released, dcache_req_valid=0, dcache_req_type=READ, addr/data=0, fill_valid=0, fill addr/data=0, errors=0.
REQ-038 SHALL abandon any in-flight transaction on reset mid-operation; a later response is flagged spurious.

Verification
REQ-039 SHALL cover clean miss addr 0x00123, ready=1, resp data 0xA5.. 2 cycles after read -> one READ req addr 0x00123, fill_valid pulse with 0xA5.. addr 0x00123.
REQ-040 SHALL cover dirty miss victim 0x00040 data 0x11.., fill 0x00080 -> WRITE 0x00040 handshake precedes READ 0x00080, then fill.
REQ-041 SHALL cover dcache_req_ready held 0 for 5 cycles -> req outputs stable all 5 cycles, single handshake.
REQ-042 SHALL cover RESP_TIMEOUT_CYCLES=4, no response -> timeout_err=1 after 4 RD_WAIT cycles; late response still fills.
REQ-043 SHALL cover resp_valid in IDLE -> spurious_resp_err=1, fill_valid stays 0.
REQ-044 SHALL cover rst_aL low during RD_WAIT -> outputs reset values same cycle, miss_ready=1 after release.

Source files
------------

// File: rtl/dcache_miss_handler.sv
// Data-cache miss handler: optional dirty-victim writeback, then block read and a
// one-cycle fill pulse back to the dcache, with sticky timeout/spurious-response flags.
package dcache_miss_pkg;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 64;
   typedef logic [ADDR_W-1:0] main_mem_block_addr_t;
   typedef logic [DATA_W-1:0] block_data_t;
   typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_t;
endpackage

module dcache_miss_handler
   import dcache_miss_pkg::*;
#(
   parameter int RESP_TIMEOUT_CYCLES = 1023
) (
   input  logic                 clk,
   input  logic                 rst_aL,
   input  logic                 miss_valid,
   output logic                 miss_ready,
   input  main_mem_block_addr_t miss_block_addr,
   input  logic                 miss_victim_dirty,
   input  main_mem_block_addr_t miss_victim_block_addr,
   input  block_data_t          miss_victim_block_data,
   output logic                 dcache_req_valid,
   output req_type_t            dcache_req_type,
   output main_mem_block_addr_t dcache_req_block_addr,
   output block_data_t          dcache_req_block_data,
   input  logic                 dcache_req_ready,
   input  logic                 dcache_resp_valid,
   input  block_data_t          dcache_resp_block_data,
   output logic                 fill_valid,
   output main_mem_block_addr_t fill_block_addr,
   output block_data_t          fill_block_data,
   output logic                 timeout_err,
   output logic                 spurious_resp_err
);
   typedef enum logic [2:0] {IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL} state_t;

   // One spare bit so the saturation value always lies beyond the timeout point.
   localparam int CNT_W = $clog2(RESP_TIMEOUT_CYCLES + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] TMO_LAST =
      CNT_W'((RESP_TIMEOUT_CYCLES == 0) ? 0 : RESP_TIMEOUT_CYCLES - 1);

   state_t               state_reg, state_next;
   main_mem_block_addr_t miss_addr_reg;
   main_mem_block_addr_t victim_addr_reg;
   block_data_t          victim_data_reg;
   block_data_t          rd_data_reg;
   logic [CNT_W-1:0]     rd_cnt_reg;
   logic                 timeout_err_reg;
   logic                 spurious_err_reg;

   assign timeout_err       = timeout_err_reg;
   assign spurious_resp_err = spurious_err_reg;

   always_comb begin
      state_next            = state_reg;
      miss_ready            = 1'b0;
      dcache_req_valid      = 1'b0;
      dcache_req_type       = REQ_READ;
      dcache_req_block_addr = '0;
      dcache_req_block_data = '0;
      fill_valid            = 1'b0;
      fill_block_addr       = '0;
      fill_block_data       = '0;
      unique case (state_reg)
         IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) begin
               state_next = miss_victim_dirty ? WB_REQ : RD_REQ;
            end
         end
         WB_REQ: begin
            dcache_req_valid      = 1'b1;
            dcache_req_type       = REQ_WRITE;
            dcache_req_block_addr = victim_addr_reg;
            dcache_req_block_data = victim_data_reg;
            if (dcache_req_ready) begin
               state_next = RD_REQ;
            end
         end
         RD_REQ: begin
            dcache_req_valid      = 1'b1;
            dcache_req_block_addr = miss_addr_reg;
            if (dcache_req_ready) begin
               state_next = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (dcache_resp_valid) begin
               state_next = FILL;
            end
         end
         FILL: begin
            fill_valid      = 1'b1;
            fill_block_addr = miss_addr_reg;
            fill_block_data = rd_data_reg;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         state_reg        <= IDLE;
         miss_addr_reg    <= '0;
         victim_addr_reg  <= '0;
         victim_data_reg  <= '0;
         rd_data_reg      <= '0;
         rd_cnt_reg       <= '0;
         timeout_err_reg  <= 1'b0;
         spurious_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && miss_valid) begin
            miss_addr_reg   <= miss_block_addr;
            victim_addr_reg <= miss_victim_block_addr;
            victim_data_reg <= miss_victim_block_data;
         end
         if (state_reg == RD_WAIT && dcache_resp_valid) begin
            rd_data_reg <= dcache_resp_block_data;
         end
         // Held at zero outside RD_WAIT, so every wait starts counting from zero.
         if (state_reg != RD_WAIT) begin
            rd_cnt_reg <= '0;
         end else if (rd_cnt_reg != CNT_MAX) begin
            rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
         end
         if (RESP_TIMEOUT_CYCLES != 0 && state_reg == RD_WAIT && !dcache_resp_valid
             && rd_cnt_reg == TMO_LAST) begin
            timeout_err_reg <= 1'b1;
         end
         if (dcache_resp_valid && state_reg != RD_WAIT) begin
            spurious_err_reg <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dcache_miss_handler.sv
// Randomised bench for dcache_miss_handler: a request-queue model predicts every
// output each cycle; directed cases pin latencies, ordering, timeout and reset.
`timescale 1ns/1ps
module tb_dcache_miss_handler;
   import dcache_miss_pkg::*;
   localparam int TMO = 4;

   logic                 clk = 1'b0;
   logic                 rst_aL = 1'b0;
   logic                 miss_valid = 1'b0;
   logic                 miss_ready;
   main_mem_block_addr_t miss_block_addr = '0;
   logic                 miss_victim_dirty = 1'b0;
   main_mem_block_addr_t miss_victim_block_addr = '0;
   block_data_t          miss_victim_block_data = '0;
   logic                 dcache_req_valid;
   req_type_t            dcache_req_type;
   main_mem_block_addr_t dcache_req_block_addr;
   block_data_t          dcache_req_block_data;
   logic                 dcache_req_ready = 1'b0;
   logic                 dcache_resp_valid = 1'b0;
   block_data_t          dcache_resp_block_data = '0;
   logic                 fill_valid;
   main_mem_block_addr_t fill_block_addr;
   block_data_t          fill_block_data;
   logic                 timeout_err;
   logic                 spurious_resp_err;

   dcache_miss_handler #(.RESP_TIMEOUT_CYCLES(TMO)) dut (
      .clk                    (clk),
      .rst_aL                 (rst_aL),
      .miss_valid             (miss_valid),
      .miss_ready             (miss_ready),
      .miss_block_addr        (miss_block_addr),
      .miss_victim_dirty      (miss_victim_dirty),
      .miss_victim_block_addr (miss_victim_block_addr),
      .miss_victim_block_data (miss_victim_block_data),
      .dcache_req_valid       (dcache_req_valid),
      .dcache_req_type        (dcache_req_type),
      .dcache_req_block_addr  (dcache_req_block_addr),
      .dcache_req_block_data  (dcache_req_block_data),
      .dcache_req_ready       (dcache_req_ready),
      .dcache_resp_valid      (dcache_resp_valid),
      .dcache_resp_block_data (dcache_resp_block_data),
      .fill_valid             (fill_valid),
      .fill_block_addr        (fill_block_addr),
      .fill_block_data        (fill_block_data),
      .timeout_err            (timeout_err),
      .spurious_resp_err      (spurious_resp_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a miss becomes a queue of memory requests, then a wait for the read
   // data, then one fill cycle; errors are sticky booleans.
   typedef struct packed {
      logic                 wr;
      main_mem_block_addr_t addr;
      block_data_t          data;
   } req_t;

   req_t                 exp_q[$];
   bit                   m_busy = 0, m_fill = 0, m_tmo = 0, m_spur = 0;
   main_mem_block_addr_t m_fill_addr = '0;
   block_data_t          m_fill_data = '0;
   int                   m_wait = 0, cyc = 0, m_acc_cyc = 0, n_hs = 0;
   bit                   first_hs_wr = 0;

   function automatic bit awaiting();
      return m_busy && exp_q.size() == 0 && !m_fill;
   endfunction

   function automatic req_t mk_req(input logic wr, input main_mem_block_addr_t a, input block_data_t d);
      req_t r;
      r.wr = wr;
      r.addr = a;
      r.data = d;
      return r;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_aL);
      if (!rst_aL) begin
         exp_q.delete();
         m_busy = 0; m_fill = 0; m_tmo = 0; m_spur = 0; m_wait = 0;
      end else begin
         cyc++;
         if (dcache_resp_valid && !awaiting()) m_spur = 1;
         if (m_fill) begin
            m_fill = 0;
            m_busy = 0;
         end else if (!m_busy) begin
            if (miss_valid) begin
               m_busy = 1; m_acc_cyc = cyc; n_hs = 0; m_fill_addr = miss_block_addr;
               if (miss_victim_dirty)
                  exp_q.push_back(mk_req(1'b1, miss_victim_block_addr, miss_victim_block_data));
               exp_q.push_back(mk_req(1'b0, miss_block_addr, '0));
            end
         end else if (exp_q.size() != 0) begin
            if (dcache_req_ready) begin
               if (n_hs == 0) first_hs_wr = exp_q[0].wr;
               n_hs++;
               void'(exp_q.pop_front());
               m_wait = 0;
            end
         end else if (dcache_resp_valid) begin
            m_fill = 1;
            m_fill_data = dcache_resp_block_data;
         end else begin
            m_wait++;
            if (m_wait == TMO) m_tmo = 1;
         end
      end
   end

   int                   stall_cnt = 0, last_lat = 0;
   main_mem_block_addr_t last_fill_addr = '0, hs_wr_addr = '0;
   block_data_t          last_fill_data = '0, hs_wr_data = '0;

   initial forever begin
      @(negedge clk);
      chk("miss_ready", miss_ready, !m_busy);
      chk("req_valid", dcache_req_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         chk("req_type", dcache_req_type, exp_q[0].wr);
         chk("req_addr", dcache_req_block_addr, exp_q[0].addr);
         chk("req_data", dcache_req_block_data, exp_q[0].data);
         if (!dcache_req_ready) stall_cnt++;
         if (dcache_req_ready && dcache_req_type == REQ_WRITE) begin
            hs_wr_addr = dcache_req_block_addr;
            hs_wr_data = dcache_req_block_data;
         end
      end
      chk("fill_valid", fill_valid, m_fill);
      if (m_fill) begin
         chk("fill_addr", fill_block_addr, m_fill_addr);
         chk("fill_data", fill_block_data, m_fill_data);
         last_lat = cyc + 1 - m_acc_cyc;
         last_fill_addr = fill_block_addr;
         last_fill_data = fill_block_data;
      end
      chk("timeout_err", timeout_err, m_tmo);
      chk("spurious_err", spurious_resp_err, m_spur);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_valid"}, dcache_req_valid, 0);
      chk({tag, "_req_type"}, dcache_req_type, REQ_READ);
      chk({tag, "_req_addr"}, dcache_req_block_addr, 0);
      chk({tag, "_req_data"}, dcache_req_block_data, 0);
      chk({tag, "_fill_valid"}, fill_valid, 0);
      chk({tag, "_fill_addr"}, fill_block_addr, 0);
      chk({tag, "_fill_data"}, fill_block_data, 0);
      chk({tag, "_timeout"}, timeout_err, 0);
      chk({tag, "_spurious"}, spurious_resp_err, 0);
   endtask

   task automatic do_miss(input main_mem_block_addr_t addr, input bit dirty,
                          input main_mem_block_addr_t vaddr, input block_data_t vdata,
                          input int ready_pct, input int ready_lo, input int delay,
                          input block_data_t rdata, input bit tmo_probe);
      int w = 0;
      int n = 0;
      bit sent = 0;
      stall_cnt = 0;
      miss_valid = 1'b1;
      miss_block_addr = addr;
      miss_victim_dirty = dirty;
      miss_victim_block_addr = vaddr;
      miss_victim_block_data = vdata;
      step();
      while (m_busy && n < 200) begin
         // Scribble on the miss inputs while busy; the captured values must not move.
         miss_valid = !m_fill && ($urandom_range(0, 1) == 1);
         miss_block_addr = main_mem_block_addr_t'($urandom);
         miss_victim_dirty = 1'($urandom_range(0, 1));
         miss_victim_block_addr = main_mem_block_addr_t'($urandom);
         miss_victim_block_data = {$urandom, $urandom};
         dcache_req_ready = (n < ready_lo) ? 1'b0 : ($urandom_range(1, 100) <= ready_pct);
         dcache_resp_valid = 1'b0;
         if (awaiting() && !sent) begin
            if (tmo_probe && w == TMO - 1) chk("timeout_before_limit", timeout_err, 0);
            if (tmo_probe && w == TMO) chk("timeout_at_limit", timeout_err, 1);
            if (w >= delay) begin
               dcache_resp_valid = 1'b1;
               dcache_resp_block_data = rdata;
               sent = 1;
            end
            w++;
         end
         n++;
         step();
      end
      chk("miss_completes", m_busy, 0);
      miss_valid = 1'b0;
      dcache_req_ready = 1'b0;
      dcache_resp_valid = 1'b0;
      $display("miss addr=%h dirty=%0d handshakes=%0d latency=%0d", addr, dirty, n_hs, last_lat);
   endtask

   initial begin
      block_data_t a5 = {8{8'hA5}};
      block_data_t d11 = {8{8'h11}};
      block_data_t rd;
      int k;

      rst_aL = 1'b0;
      repeat (3) step();
      chk_reset("por");
      rst_aL = 1'b1;
      step();
      chk("miss_ready_after_por", miss_ready, 1);

      // Clean miss, response two cycles into the wait.
      do_miss(20'h00123, 0, '0, '0, 100, 0, 2, a5, 0);
      chk("clean_hs_count", n_hs, 1);
      chk("clean_first_is_read", first_hs_wr, 0);
      chk("clean_fill_addr", last_fill_addr, 20'h00123);
      chk("clean_fill_data", last_fill_data, a5);
      chk("clean_lat_d2", last_lat, 5);

      // Minimum latency clean and dirty.
      do_miss(20'h00555, 0, '0, '0, 100, 0, 1, 64'h0123_4567_89AB_CDEF, 0);
      chk("clean_min_lat", last_lat, 4);
      do_miss(20'h00080, 1, 20'h00040, d11, 100, 0, 1, 64'hFEDC_BA98_7654_3210, 0);
      chk("dirty_hs_count", n_hs, 2);
      chk("dirty_write_first", first_hs_wr, 1);
      chk("dirty_wr_addr", hs_wr_addr, 20'h00040);
      chk("dirty_wr_data", hs_wr_data, d11);
      chk("dirty_fill_addr", last_fill_addr, 20'h00080);
      chk("dirty_min_lat", last_lat, 5);

      // Back-pressure for five cycles.
      do_miss(20'h0ABCD, 0, '0, '0, 100, 5, 0, 64'h5A5A_0000_FFFF_1234, 0);
      chk("stall_cycles", stall_cnt, 5);
      chk("stall_hs_count", n_hs, 1);

      for (int i = 0; i < 150; i++) begin
         rd = {$urandom, $urandom};
         do_miss(main_mem_block_addr_t'($urandom), 1'($urandom_range(0, 1)),
                 main_mem_block_addr_t'($urandom), {$urandom, $urandom},
                 $urandom_range(30, 100), 0, $urandom_range(0, TMO - 1), rd, 0);
      end
      chk("random_no_timeout", timeout_err, 0);
      chk("random_no_spurious", spurious_resp_err, 0);

      // No response for longer than the limit; the late response still fills.
      do_miss(20'h00777, 0, '0, '0, 100, 0, TMO + 2, 64'hC0FF_EE00_D00D_BEEF, 1);
      chk("timeout_sticky", timeout_err, 1);
      chk("late_fill_data", last_fill_data, 64'hC0FF_EE00_D00D_BEEF);

      rst_aL = 1'b0;
      step();
      chk_reset("rst2");
      rst_aL = 1'b1;
      step();

      // Response while idle.
      dcache_resp_valid = 1'b1;
      dcache_resp_block_data = a5;
      step();
      dcache_resp_valid = 1'b0;
      chk("idle_resp_spurious", spurious_resp_err, 1);
      chk("idle_resp_no_fill", fill_valid, 0);
      step();
      chk("idle_resp_no_fill_later", fill_valid, 0);

      rst_aL = 1'b0;
      step();
      rst_aL = 1'b1;
      step();

      // Reset in the middle of a read wait.
      miss_valid = 1'b1;
      miss_block_addr = 20'h00321;
      miss_victim_dirty = 1'b0;
      step();
      miss_valid = 1'b0;
      dcache_req_ready = 1'b1;
      k = 0;
      while (!awaiting() && k < 20) begin
         step();
         k++;
      end
      chk("reached_rd_wait", awaiting(), 1);
      step();
      step();
      #1;
      rst_aL = 1'b0;
      #1;
      chk_reset("rst_mid");
      step();
      step();
      rst_aL = 1'b1;
      step();
      chk("miss_ready_after_mid_rst", miss_ready, 1);
      dcache_resp_valid = 1'b1;
      step();
      dcache_resp_valid = 1'b0;
      chk("late_resp_spurious", spurious_resp_err, 1);
      chk("late_resp_no_fill", fill_valid, 0);
      dcache_req_ready = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
